// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
// Stage/beat sequencer for an in-place radix-2 FFT datapath. A start request
// with a runtime size walks all log2(N) stages. Each stage issues its beats,
// then drains the butterfly pipeline and toggles the ping-pong bank.
// Every output is a flop, so there is no combinational path from input to output.
// Optional build macro: FFT_SEQ_PERF_EN adds saturating cycle/stall counters.
module fft_stage_sequencer #(
  parameter int LOG2_MAX_POINTS = 10,
  parameter int CALCS_PER_CYCLE = 4,
  parameter int DELAY           = 5,
  localparam int LW       = $clog2(LOG2_MAX_POINTS + 1),
  localparam int SW       = $clog2(LOG2_MAX_POINTS),
  localparam int MIN_LOG2 = $clog2(2 * CALCS_PER_CYCLE)
) (
  input  logic                       clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [LW-1:0]              i_log2_points,
  input  logic                       i_stall,
  output logic                       o_busy,
  output logic                       o_issue_valid,
  output logic [LOG2_MAX_POINTS-1:0] o_beat,
  output logic [SW-1:0]              o_stage,
  output logic [LOG2_MAX_POINTS-1:0] o_stride,
  output logic                       o_read_bank,
  output logic                       o_new_stage_trigger,
  output logic                       o_done,
  output logic                       o_cfg_err
`ifdef FFT_SEQ_PERF_EN
  ,
  output logic [31:0]                o_cycle_count,
  output logic [31:0]                o_stall_count
`endif
);

  localparam int BW = LOG2_MAX_POINTS;
  localparam int DW = (DELAY > 1) ? $clog2(DELAY) : 1;

  localparam logic [LW-1:0] L_MIN      = LW'(MIN_LOG2);
  localparam logic [LW-1:0] L_MAX      = LW'(LOG2_MAX_POINTS);
  localparam logic [LW-1:0] L_ONE      = LW'(1'b1);
  localparam logic [BW-1:0] BEAT_ONE   = BW'(1'b1);
  localparam logic [SW-1:0] STAGE_ONE  = SW'(1'b1);
  localparam logic [DW-1:0] DRAIN_ONE  = DW'(1'b1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DELAY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Stride of a stage: (N/2) >> stage, with N = 2^l.
  function automatic logic [BW-1:0] stride_f(input logic [LW-1:0] l,
                                             input logic [SW-1:0] s);
    logic [BW-1:0] half_n;
    half_n = BEAT_ONE << (l - L_ONE);
    return half_n >> s;
  endfunction

  state_t          state_r, state_nx;
  logic [LW-1:0]   l_r, l_nx;
  logic [SW-1:0]   stage_r, stage_nx;
  logic [BW-1:0]   beat_r, beat_nx;
  logic [DW-1:0]   drain_r, drain_nx;
  logic            bank_r, bank_nx;
  logic            issue_r, issue_nx;
  logic            busy_r, busy_nx;
  logic [BW-1:0]   stride_r, stride_nx;
  logic            trig_r, trig_nx;
  logic            done_r, done_nx;
  logic            cfg_err_r, cfg_err_nx;

  logic [BW-1:0]   last_beat_s;
  logic [SW-1:0]   last_stage_s;
  logic [SW-1:0]   last_stage_nx_s;
  logic            drain_end_nx_s;

  // Limits of the transform in flight, derived from the captured size.
  always_comb begin
    last_beat_s  = (BEAT_ONE << (l_r - L_MIN)) - BEAT_ONE;
    last_stage_s = SW'(l_r - L_ONE);
  end

  // Next-state logic. An invalid ISSUE cycle always follows an issued beat,
  // so beat_r is the last beat issued and advances only when the next issues.
  always_comb begin
    state_nx   = state_r;
    l_nx       = l_r;
    stage_nx   = stage_r;
    beat_nx    = beat_r;
    drain_nx   = drain_r;
    bank_nx    = bank_r;
    issue_nx   = 1'b0;
    cfg_err_nx = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (i_start) begin
          if ((i_log2_points >= L_MIN) && (i_log2_points <= L_MAX)) begin
            state_nx = S_ISSUE;
            l_nx     = i_log2_points;
            stage_nx = '0;
            beat_nx  = '0;
            drain_nx = '0;
            bank_nx  = 1'b0;
            issue_nx = 1'b1;
          end else begin
            cfg_err_nx = 1'b1;
          end
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (issue_r && (beat_r == last_beat_s)) begin
          state_nx = S_DRAIN;
          drain_nx = '0;
        end else if (!i_stall) begin
          beat_nx  = beat_r + BEAT_ONE;
          issue_nx = 1'b1;
        end else begin
          issue_nx = 1'b0;
        end
      end
      S_DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          if (stage_r == last_stage_s) begin
            state_nx = S_IDLE;
            stage_nx = '0;
            beat_nx  = '0;
            drain_nx = '0;
            bank_nx  = 1'b0;
          end else begin
            state_nx = S_ISSUE;
            stage_nx = stage_r + STAGE_ONE;
            beat_nx  = '0;
            drain_nx = '0;
            bank_nx  = ~bank_r;
            issue_nx = 1'b1;
          end
        end else begin
          drain_nx = drain_r + DRAIN_ONE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        stage_nx = '0;
        beat_nx  = '0;
        drain_nx = '0;
        bank_nx  = 1'b0;
      end
    endcase
  end

  // Decode the registered outputs from the next state so they appear in the cycle they describe.
  always_comb begin
    busy_nx         = (state_nx != S_IDLE);
    last_stage_nx_s = SW'(l_nx - L_ONE);
    drain_end_nx_s  = (state_nx == S_DRAIN) && (drain_nx == DRAIN_LAST);
    trig_nx         = drain_end_nx_s && (stage_nx != last_stage_nx_s);
    done_nx         = drain_end_nx_s && (stage_nx == last_stage_nx_s);
    if (busy_nx) begin
      stride_nx = stride_f(l_nx, stage_nx);
    end else begin
      stride_nx = '0;
    end
  end

  // Sequencer state and output registers; reset abandons any transform in flight.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_r   <= S_IDLE;
      l_r       <= '0;
      stage_r   <= '0;
      beat_r    <= '0;
      drain_r   <= '0;
      bank_r    <= 1'b0;
      issue_r   <= 1'b0;
      busy_r    <= 1'b0;
      stride_r  <= '0;
      trig_r    <= 1'b0;
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
    end else begin
      state_r   <= state_nx;
      l_r       <= l_nx;
      stage_r   <= stage_nx;
      beat_r    <= beat_nx;
      drain_r   <= drain_nx;
      bank_r    <= bank_nx;
      issue_r   <= issue_nx;
      busy_r    <= busy_nx;
      stride_r  <= stride_nx;
      trig_r    <= trig_nx;
      done_r    <= done_nx;
      cfg_err_r <= cfg_err_nx;
    end
  end

  assign o_busy              = busy_r;
  assign o_issue_valid       = issue_r;
  assign o_beat              = beat_r;
  assign o_stage             = stage_r;
  assign o_stride            = stride_r;
  assign o_read_bank         = bank_r;
  assign o_new_stage_trigger = trig_r;
  assign o_done              = done_r;
  assign o_cfg_err           = cfg_err_r;

`ifdef FFT_SEQ_PERF_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] cycle_cnt_r;
  logic [31:0] stall_cnt_r;

  // Saturating busy-cycle and issue-stall counters, cleared when a start is accepted.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      cycle_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else if ((state_r == S_IDLE) && (state_nx == S_ISSUE)) begin
      cycle_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (busy_r && (cycle_cnt_r != CNT_MAX)) begin
        cycle_cnt_r <= cycle_cnt_r + 32'd1;
      end else begin
        cycle_cnt_r <= cycle_cnt_r;
      end
      if ((state_r == S_ISSUE) && i_stall && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign o_cycle_count = cycle_cnt_r;
  assign o_stall_count = stall_cnt_r;
`endif

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed bench for fft_stage_sequencer with the
// default parameters (LOG2_MAX_POINTS=10, CALCS_PER_CYCLE=4, DELAY=5).
// Cycle numbers are relative to the accepting edge t: cycle k is the cycle
// after the k-th rising edge following t-1. Outputs are sampled 1 time unit
// after each rising edge.
module tb_fft_stage_sequencer;
  localparam int LMAX = 10;
  localparam int LW   = $clog2(LMAX + 1);
  localparam int SW   = $clog2(LMAX);

  logic            clk = 1'b0;
  logic            i_reset;
  logic            i_start;
  logic [LW-1:0]   i_log2_points;
  logic            i_stall;
  logic            o_busy;
  logic            o_issue_valid;
  logic [LMAX-1:0] o_beat;
  logic [SW-1:0]   o_stage;
  logic [LMAX-1:0] o_stride;
  logic            o_read_bank;
  logic            o_new_stage_trigger;
  logic            o_done;
  logic            o_cfg_err;
`ifdef FFT_SEQ_PERF_EN
  logic [31:0]     o_cycle_count;
  logic [31:0]     o_stall_count;
`endif

  int checks = 0;
  int errors = 0;
  int dc, tn, isn, cnt;

  fft_stage_sequencer #(
    .LOG2_MAX_POINTS(10),
    .CALCS_PER_CYCLE(4),
    .DELAY(5)
  ) dut (
    .clk(clk),
    .i_reset(i_reset),
    .i_start(i_start),
    .i_log2_points(i_log2_points),
    .i_stall(i_stall),
    .o_busy(o_busy),
    .o_issue_valid(o_issue_valid),
    .o_beat(o_beat),
    .o_stage(o_stage),
    .o_stride(o_stride),
    .o_read_bank(o_read_bank),
    .o_new_stage_trigger(o_new_stage_trigger),
    .o_done(o_done),
    .o_cfg_err(o_cfg_err)
`ifdef FFT_SEQ_PERF_EN
    ,
    .o_cycle_count(o_cycle_count),
    .o_stall_count(o_stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_issue"}, o_issue_valid, 0);
    chk({tag, "_beat"}, o_beat, 0);
    chk({tag, "_stage"}, o_stage, 0);
    chk({tag, "_stride"}, o_stride, 0);
    chk({tag, "_bank"}, o_read_bank, 0);
    chk({tag, "_trig"}, o_new_stage_trigger, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_cfgerr"}, o_cfg_err, 0);
  endtask

  // Runs from cycle c0 until o_done (stays in the done cycle). With per > 0,
  // checks the first beat of each stage at cycles 1 + k*per.
  task automatic run_done(input string tag, input int c0, input int l, input int per,
                          input int limit, output int done_c, output int trig_n,
                          output int iss_n);
    int coinc;
    coinc  = 0;
    done_c = -1;
    trig_n = 0;
    iss_n  = 0;
    for (int c = c0; c <= limit; c++) begin
      if (per > 0 && ((c - 1) % per) == 0) begin
        int k;
        k = (c - 1) / per;
        chk({tag, "_st_issue"}, o_issue_valid, 1);
        chk({tag, "_st_beat"}, o_beat, 0);
        chk({tag, "_st_stage"}, o_stage, k);
        chk({tag, "_st_bank"}, o_read_bank, k % 2);
        chk({tag, "_st_stride"}, o_stride, (1 << (l - 1)) >> k);
      end
      if (o_new_stage_trigger) trig_n++;
      if (o_issue_valid) iss_n++;
      if ((int'(o_done) + int'(o_new_stage_trigger) + int'(o_issue_valid)) > 1) coinc++;
      if (o_done) begin
        done_c = c;
        break;
      end
      tick();
    end
    chk({tag, "_coincide"}, coinc, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_log2_points = '0;
    i_stall = 1'b0;
    repeat (2) tick();
    chk_zero("reset");
    i_reset = 1'b0;
    tick();
    chk_zero("idle");

    // L=4, B=2, stage period 7; a start while busy is ignored.
    i_start = 1'b1; i_log2_points = 4'd4;
    tick();                                   // cycle 1
    i_start = 1'b0;
    chk("l4_c1_busy", o_busy, 1);
    chk("l4_c1_issue", o_issue_valid, 1);
    chk("l4_c1_beat", o_beat, 0);
    chk("l4_c1_stride", o_stride, 8);
    chk("l4_c1_bank", o_read_bank, 0);
    tick();                                   // cycle 2
    chk("l4_c2_issue", o_issue_valid, 1);
    chk("l4_c2_beat", o_beat, 1);
    tick();                                   // cycle 3
    chk("l4_c3_issue", o_issue_valid, 0);
    repeat (3) tick();                        // cycle 6
    chk("l4_c6_trig", o_new_stage_trigger, 0);
    tick();                                   // cycle 7
    chk("l4_c7_trig", o_new_stage_trigger, 1);
    chk("l4_c7_done", o_done, 0);
    tick();                                   // cycle 8
    chk("l4_c8_issue", o_issue_valid, 1);
    chk("l4_c8_beat", o_beat, 0);
    chk("l4_c8_stage", o_stage, 1);
    chk("l4_c8_bank", o_read_bank, 1);
    chk("l4_c8_stride", o_stride, 4);
    chk("l4_c8_trig", o_new_stage_trigger, 0);
    repeat (2) tick();                        // cycle 10
    i_start = 1'b1; i_log2_points = 4'd2;
    tick();                                   // cycle 11
    i_start = 1'b0;
    chk("busy_start_cfgerr", o_cfg_err, 0);
    chk("busy_start_stage", o_stage, 1);
    run_done("l4", 11, 4, 7, 200, dc, tn, isn);
    chk("l4_done_cycle", dc, 28);
    chk("l4_trig_count", tn, 2);
    chk("l4_issue_count", isn, 4);
    chk("l4_done_stage", o_stage, 3);
    chk("l4_done_stride", o_stride, 1);
    tick();                                   // cycle 29
    chk("l4_after_busy", o_busy, 0);
    chk("l4_after_done", o_done, 0);

    // L=10, started in the first cycle after the previous o_done.
    i_start = 1'b1; i_log2_points = 4'd10;
    tick();
    i_start = 1'b0;
    run_done("l10", 1, 10, 133, 2000, dc, tn, isn);
    chk("l10_done_cycle", dc, 1330);
    chk("l10_trig_count", tn, 9);
    chk("l10_issue_count", isn, 1280);
    tick();
    chk("l10_after_busy", o_busy, 0);

    // L=3, minimum legal size, B=1.
    i_start = 1'b1; i_log2_points = 4'd3;
    tick();
    i_start = 1'b0;
    run_done("l3", 1, 3, 6, 200, dc, tn, isn);
    chk("l3_done_cycle", dc, 18);
    chk("l3_trig_count", tn, 2);
    chk("l3_issue_count", isn, 3);
    tick();
    chk("l3_after_busy", o_busy, 0);

    // Illegal sizes.
    i_start = 1'b1; i_log2_points = 4'd2;
    tick();
    i_start = 1'b0;
    chk("l2_cfgerr", o_cfg_err, 1);
    chk("l2_busy", o_busy, 0);
    chk("l2_issue", o_issue_valid, 0);
    tick();
    chk("l2_cfgerr_pulse", o_cfg_err, 0);
    chk("l2_busy_after", o_busy, 0);
    i_start = 1'b1; i_log2_points = 4'd11;
    tick();
    i_start = 1'b0;
    chk("l11_cfgerr", o_cfg_err, 1);
    chk("l11_busy", o_busy, 0);
    tick();
    chk("l11_cfgerr_pulse", o_cfg_err, 0);

    // L=4 with three stall cycles in stage 0 issue, then stall during drain.
    i_start = 1'b1; i_log2_points = 4'd4;
    tick();                                   // cycle 1
    i_start = 1'b0;
    chk("stl_c1_issue", o_issue_valid, 1);
    i_stall = 1'b1;
    tick();                                   // cycle 2
    chk("stl_c2_issue", o_issue_valid, 0);
    chk("stl_c2_beat", o_beat, 0);
    tick();                                   // cycle 3
    chk("stl_c3_issue", o_issue_valid, 0);
    tick();                                   // cycle 4
    chk("stl_c4_issue", o_issue_valid, 0);
    chk("stl_c4_beat", o_beat, 0);
    chk("stl_c4_busy", o_busy, 1);
    i_stall = 1'b0;
    tick();                                   // cycle 5
    chk("stl_c5_issue", o_issue_valid, 1);
    chk("stl_c5_beat", o_beat, 1);
    tick();                                   // cycle 6
    i_stall = 1'b1;
    repeat (4) tick();                        // cycle 10
    chk("stl_c10_trig", o_new_stage_trigger, 1);
    tick();                                   // cycle 11
    i_stall = 1'b0;
    chk("stl_c11_issue", o_issue_valid, 1);
    chk("stl_c11_stage", o_stage, 1);
    chk("stl_c11_bank", o_read_bank, 1);
    run_done("stl", 11, 4, 0, 200, dc, tn, isn);
    chk("stl_done_cycle", dc, 31);
    tick();                                   // cycle 32
    chk("stl_after_busy", o_busy, 0);
`ifdef FFT_SEQ_PERF_EN
    chk("perf_cycle_count", o_cycle_count, 31);
    chk("perf_stall_count", o_stall_count, 3);
`endif

    // Asynchronous reset in stage 2, then a clean restart.
    i_start = 1'b1; i_log2_points = 4'd4;
    tick();                                   // cycle 1
    i_start = 1'b0;
    repeat (15) tick();                       // cycle 16
    chk("rst_mid_stage", o_stage, 2);
    chk("rst_mid_issue", o_issue_valid, 1);
    i_reset = 1'b1;
    #1;
    chk_zero("rst_async");
    repeat (2) tick();
    i_reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_done || o_busy) cnt++;
      tick();
    end
    chk("rst_no_done", cnt, 0);
    i_start = 1'b1; i_log2_points = 4'd4;
    tick();
    i_start = 1'b0;
    run_done("rst_restart", 1, 4, 7, 200, dc, tn, isn);
    chk("rst_restart_done", dc, 28);
    chk("rst_restart_trig", tn, 3);
    chk("rst_restart_issue", isn, 8);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

- Parametrised stage/beat sequencer for the in-place radix-2 FFT datapath.
- Accepts a start request with a runtime transform size and walks all log2(N) stages, issuing CALCS_PER_CYCLE butterflies per beat.
- Drains the butterfly pipeline between stages, toggles the ping-pong SRAM bank, and signals completion.
- Compared with the fixed 4-wide controller, it adds start/stall/done handshakes, size validation and parametrised width, lane count and pipeline depth.

## Interface

Parameters:
- LOG2_MAX_POINTS, 10 — largest supported transform is 2^LOG2_MAX_POINTS points.
- CALCS_PER_CYCLE, 4 — butterflies issued per beat; power of two, ≥1.
- DELAY, 5 — butterfly pipeline latency in cycles; ≥1.
- Derived:
  - LW = $clog2(LOG2_MAX_POINTS+1)
  - SW = $clog2(LOG2_MAX_POINTS)
  - MIN_LOG2 = $clog2(2*CALCS_PER_CYCLE)

Ports:
- clk, input, 1 — single clock; all logic on the rising edge.
- i_reset, input, 1 — asynchronous, active-high reset.
- i_start, input, 1 — start request; sampled only in IDLE.
- i_log2_points, input, LW — log2(N) for the requested transform; captured when a start is accepted.
- i_stall, input, 1 — holds beat issue; does not affect drain.
- o_busy, output, 1 — high from the cycle after an accepted start through the o_done cycle.
- o_issue_valid, output, 1 — a beat is issued this cycle.
- o_beat, output, LOG2_MAX_POINTS — beat index within the current stage.
- o_stage, output, SW — current stage index, 0-based.
- o_stride, output, LOG2_MAX_POINTS — butterfly stride for the current stage, (N/2) >> stage.
- o_read_bank, output, 1 — ping-pong bank being read; the write bank is its inverse.
- o_new_stage_trigger, output, 1 — one-cycle pulse at the end of a non-final stage.
- o_done, output, 1 — one-cycle pulse at the end of the final stage.
- o_cfg_err, output, 1 — one-cycle pulse when a start is rejected.

## Operation

State machine, three states:
- IDLE → ISSUE
  - On i_start with MIN_LOG2 ≤ i_log2_points ≤ LOG2_MAX_POINTS.
  - Capture L, set stage=0, beat=0, bank=0.
- IDLE, illegal size
  - On i_start with an illegal i_log2_points: o_cfg_err=1 the next cycle and remain in IDLE.
- ISSUE
  - B = 2^(L-1) / CALCS_PER_CYCLE beats per stage.
  - While i_stall=0: o_issue_valid=1 and beat increments each cycle.
  - While i_stall=1: o_issue_valid=0 and beat holds.
  - After the beat B-1 issue cycle → DRAIN.
- DRAIN
  - Counts DELAY cycles; i_stall is ignored.
  - Last drain cycle, non-final stage: o_new_stage_trigger=1. Next edge: stage+1, beat=0, bank toggles, → ISSUE.
  - Last drain cycle, stage L-1: o_done=1, then → IDLE.

Rules:
- i_start while busy is ignored; there is no queueing.
- o_stride is computed from the captured L, never the live input. Final stage stride = 1.
- Reset at any time forces IDLE immediately (asynchronous). An in-flight transform is abandoned and produces no o_done.
- Reset values:
  - o_busy, o_issue_valid, o_beat, o_stage, o_stride, o_read_bank: all 0.
  - o_new_stage_trigger, o_done, o_cfg_err: all 0.
  - Internal counters: 0.

## Timing

- Start accepted at edge t. First beat (o_issue_valid=1, beat 0, stage 0) is at cycle t+1.
- With no stalls, one stage takes B+DELAY cycles.
- o_done is asserted at cycle t + L·(B+DELAY), and o_busy falls the following cycle.
- Each stall cycle in ISSUE adds exactly one cycle.
- o_new_stage_trigger, o_done and the last o_issue_valid of a stage never coincide.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- A start may be accepted in the cycle after o_done.

## Configuration

FFT_SEQ_PERF_EN:
- When defined, adds two 32-bit saturating outputs, both cleared on an accepted start and on reset:
  - o_cycle_count — counts cycles while o_busy.
  - o_stall_count — counts ISSUE cycles with i_stall=1.
- When undefined, these ports and their counters do not exist.
- Sequencing is identical in both builds.

## Test plan

- Defaults, L=4 (B=2), start at t: beats at t+1,t+2; trigger at t+7; stage 1 beat 0 at t+8 with bank=1; strides 8,4,2,1; o_done at t+28.
- L=10, no stall: 10 stages × 133 cycles; o_done at t+1330; bank reads 0,1,0,1,… by stage.
- L=3 (minimum, B=1) works. L=2 → o_cfg_err pulse and o_busy stays 0. L=11 → o_cfg_err.
- L=4 with i_stall held 3 cycles during stage 0 ISSUE: o_beat holds, o_done at t+31. Stall asserted during DRAIN: no timing change.
- i_reset asserted mid-stage 2: all outputs 0 immediately and no o_done. Restart afterwards completes normally.
- With FFT_SEQ_PERF_EN, the 3-stall case above: o_cycle_count=31, o_stall_count=3.
